bsod_reset_sequencer: RTL and testbench



---
 rtl/bsod_seq_pkg.sv | 20 ++
 rtl/bsod_reset_sequencer_if.sv | 17 +
 rtl/bsod_tick_debounce.sv | 43 ++++
 rtl/bsod_reset_sequencer.sv | 132 +++++++++++++
 tb/tb_bsod_reset_sequencer.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/bsod_seq_pkg.sv
// Shared types and defaults for the BSODomizer reset sequencer.
package bsod_seq_pkg;

  typedef enum logic [1:0] {IDLE, ASSERT, GAP, WAIT} seq_state_e;

  localparam int DEF_TICK_CYCLES   = 4_000_001;
  localparam int DEF_NUM_STAGES    = 3;
  localparam int DEF_DEBOUNCE_TAPS = 2;
  localparam int DEF_PULSE_TICKS   = 1;
  localparam int DEF_GAP_TICKS     = 1;
  localparam int DEF_TIMEOUT_TICKS = 64;
  localparam int DEF_HB_BIT        = 26;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bsod_reset_sequencer_if.sv
// Key/enable/completion inputs and sequenced outputs of the reset sequencer.
interface bsod_reset_sequencer_if #(parameter int NUM_STAGES = 3);
  logic                  key_n;
  logic                  enable;
  logic                  done_in;
  logic [NUM_STAGES-1:0] stage_n;
  logic                  busy;
  logic                  done;
  logic                  fail;
  logic                  heartbeat;
  logic                  status_led;

  modport master (output key_n, enable, done_in,
                  input  stage_n, busy, done, fail, heartbeat, status_led);
  modport slave  (input  key_n, enable, done_in,
                  output stage_n, busy, done, fail, heartbeat, status_led);
endinterface

// File: rtl/bsod_tick_debounce.sv
// Sample-tick generator plus synchronised, tick-sampled key debouncer.
module bsod_tick_debounce #(
  parameter int TICK_CYCLES   = 4_000_001,
  parameter int DEBOUNCE_TAPS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic tick,
  output logic press
);
  localparam int TCW = $clog2(TICK_CYCLES);
  localparam logic [TCW-1:0] TC_LAST = TCW'(TICK_CYCLES - 1);

  logic [TCW-1:0]           cnt;
  logic [1:0]               sync;
  logic [DEBOUNCE_TAPS-1:0] taps, taps_nxt;
  logic [DEBOUNCE_TAPS:0]   taps_cat;
  logic                     db;

  assign tick     = (cnt == TC_LAST);
  // concatenate-then-truncate keeps the shift legal for a single tap
  assign taps_cat = {taps, sync[1]};
  assign taps_nxt = taps_cat[DEBOUNCE_TAPS-1:0];
  assign press    = tick && db && (taps_nxt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      sync <= '1;
      taps <= '1;
      db   <= 1'b1;
    end else begin
      cnt  <= tick ? '0 : cnt + TCW'(1);
      sync <= {sync[0], key_n};
      if (tick) begin
        taps <= taps_nxt;
        if (taps_nxt == '0)  db <= 1'b0;
        else if (&taps_nxt)  db <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/bsod_reset_sequencer.sv
// Power-up/reset sequencer: ordered active-low stage pulses, completion wait with timeout.
// Optional BSOD_SEQ_AUTOSTART_EN: first enabled cycle after reset starts one sequence.
module bsod_reset_sequencer
  import bsod_seq_pkg::*;
#(
  parameter int TICK_CYCLES   = DEF_TICK_CYCLES,
  parameter int NUM_STAGES    = DEF_NUM_STAGES,
  parameter int DEBOUNCE_TAPS = DEF_DEBOUNCE_TAPS,
  parameter int PULSE_TICKS   = DEF_PULSE_TICKS,
  parameter int GAP_TICKS     = DEF_GAP_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int HB_BIT        = DEF_HB_BIT
) (
  input logic clk,
  input logic reset,
  bsod_reset_sequencer_if.slave bus
);
  localparam int TW = $clog2(max3(PULSE_TICKS, GAP_TICKS, TIMEOUT_TICKS) + 1);
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_STAGES - 1);

  seq_state_e            state;
  logic [IW-1:0]         idx;
  logic [TW-1:0]         tcnt;
  logic [NUM_STAGES-1:0] stage_q;
  logic                  busy_q, done_q, fail_q, led_q;
  logic [HB_BIT:0]       hb_cnt, hb_nxt;
  logic                  tick, press, start;

  bsod_tick_debounce #(.TICK_CYCLES(TICK_CYCLES), .DEBOUNCE_TAPS(DEBOUNCE_TAPS)) u_tick (
    .clk(clk), .reset(reset), .key_n(bus.key_n), .tick(tick), .press(press)
  );

`ifdef BSOD_SEQ_AUTOSTART_EN
  logic auto_pend;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           auto_pend <= 1'b1;
    else if (bus.enable) auto_pend <= 1'b0;
  end
  assign start = bus.enable && (press || auto_pend);
`else
  assign start = bus.enable && press;
`endif

  assign hb_nxt = hb_cnt + (HB_BIT + 1)'(1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hb_cnt <= '0;
    else       hb_cnt <= hb_nxt;
  end

  // led tracks the post-edge done/busy/heartbeat, so transitions override it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      tcnt    <= '0;
      stage_q <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      led_q <= done_q | (busy_q & hb_nxt[HB_BIT]);
      if (state != IDLE && !bus.enable) begin
        state   <= IDLE;
        stage_q <= '1;
        busy_q  <= 1'b0;
        led_q   <= done_q;
      end else begin
        case (state)
          IDLE: if (start) begin
            state   <= ASSERT;
            idx     <= '0;
            tcnt    <= '0;
            stage_q <= ~NUM_STAGES'(1);
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            led_q   <= hb_nxt[HB_BIT];
          end
          ASSERT: if (tick) begin
            if (tcnt == PULSE_LAST) begin
              tcnt <= '0;
              if (idx == IDX_LAST) begin
                state   <= WAIT;
                stage_q <= '1;
              end else if (GAP_TICKS == 0) begin
                idx     <= idx + IW'(1);
                stage_q <= ~(NUM_STAGES'(1) << (idx + IW'(1)));
              end else begin
                state   <= GAP;
                stage_q <= '1;
              end
            end else tcnt <= tcnt + TW'(1);
          end
          GAP: if (tick) begin
            if (tcnt == GAP_LAST) begin
              tcnt    <= '0;
              idx     <= idx + IW'(1);
              state   <= ASSERT;
              stage_q <= ~(NUM_STAGES'(1) << (idx + IW'(1)));
            end else tcnt <= tcnt + TW'(1);
          end
          WAIT: if (bus.done_in) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            led_q  <= 1'b1;
          end else if (tick) begin
            if (tcnt == TO_LAST) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              fail_q <= 1'b1;
              led_q  <= 1'b0;
            end else tcnt <= tcnt + TW'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.stage_n    = stage_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.fail       = fail_q;
  assign bus.heartbeat  = hb_cnt[HB_BIT];
  assign bus.status_led = led_q;
endmodule

// File: tb/tb_bsod_reset_sequencer.sv
// Directed + randomized bench; expected waveforms come from edge arithmetic on the sequencing rules.
module tb_bsod_reset_sequencer;
  localparam int TC = 4, NS = 3, DT = 2, PU = 2, GA = 1, TO = 8, HB = 3;
  localparam int SEQ_LEN = ((NS - 1) * (PU + GA) + PU) * TC;
  localparam int ALL1 = (1 << NS) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, failures = 0;
  int edge_n = 0;
  int prev_done = 0, prev_fail = 0;

  bsod_reset_sequencer_if #(.NUM_STAGES(NS)) bus();

  bsod_reset_sequencer #(
    .TICK_CYCLES(TC), .NUM_STAGES(NS), .DEBOUNCE_TAPS(DT), .PULSE_TICKS(PU),
    .GAP_TICKS(GA), .TIMEOUT_TICKS(TO), .HB_BIT(HB)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // edges since reset release; the tick and heartbeat phases follow from it
  always @(posedge clk or posedge reset)
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d got=%0h want=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int b, input int d, input int f);
    int hb;
    hb = (edge_n >> HB) & 1;
    chk({tag, ".stage_n"},    32'(bus.stage_n),    32'(st));
    chk({tag, ".busy"},       32'(bus.busy),       32'(b));
    chk({tag, ".done"},       32'(bus.done),       32'(d));
    chk({tag, ".fail"},       32'(bus.fail),       32'(f));
    chk({tag, ".heartbeat"},  32'(bus.heartbeat),  32'(hb));
    chk({tag, ".status_led"}, 32'(bus.status_led), 32'(d ? 1 : (b ? hb : 0)));
  endtask

  function automatic bit key_low(input int r, input int h1, input int s2, input int l2);
    return (r >= 1 && r <= h1) || (l2 > 0 && r >= s2 && r < s2 + l2);
  endfunction

  // Relative edge r = edge_n - a0. key windows: [1,h1] and [s2,s2+l2).
  // d_rel: first edge sampling done_in high is W+d_rel (0 = never). ab_off/rst_off relative to press edge.
  task automatic run_seq(input string tag, input int h1, input int s2, input int l2, input int auto_go,
                         input int d_rel, input int ab_off, input int rst_off);
    int a0, p, w, dd, de, e, res_d, res_f, n, last_key;
    bit db, hit_rst;
    bit hist[DT];
    a0 = edge_n; p = -1; db = 1'b1; hit_rst = 1'b0; w = 0; dd = 0;
    foreach (hist[i]) hist[i] = 1'b1;
    last_key = (l2 > 0) ? s2 + l2 : h1;
    if (auto_go != 0) p = 1;
    else for (int r = 1; r < 400; r++) begin
      if ((a0 + r) % TC == 0) begin
        bit smp, same;
        smp = !key_low(r - 2, h1, s2, l2);
        for (int j = DT - 1; j > 0; j--) hist[j] = hist[j - 1];
        hist[0] = smp;
        same = 1'b1;
        for (int j = 0; j < DT; j++) if (hist[j] != smp) same = 1'b0;
        if (same && smp != db) begin
          db = smp;
          if (!smp && p < 0) p = r;   // later presses fall inside busy and are ignored
        end
      end
    end
    e = -1; res_d = prev_done; res_f = prev_fail;
    if (p >= 0) begin
      w  = p + SEQ_LEN;
      dd = w + d_rel;
      de = (dd > w) ? dd : w + 1;
      if (d_rel != 0 && de <= w + TO * TC) begin e = de; res_d = 1; res_f = 0; end
      else begin e = w + TO * TC; res_d = 0; res_f = 1; end
      if (ab_off > 0 && p + ab_off < e) begin e = p + ab_off; res_d = 0; res_f = 0; end
    end
    n = ((e > last_key) ? e : last_key) + 6 * TC;
    for (int r = 0; r <= n; r++) begin
      int st, b, d, f, off;
      st = ALL1;
      b = (p >= 0 && r >= p && r < e) ? 1 : 0;
      if (b != 0) begin
        off = r - p;
        for (int k = 0; k < NS; k++)
          if (off >= k * (PU + GA) * TC && off < k * (PU + GA) * TC + PU * TC) st &= ~(1 << k);
      end
      if (p < 0 || r < p) begin d = prev_done; f = prev_fail; end
      else if (r < e)     begin d = 0; f = 0; end
      else                begin d = res_d; f = res_f; end
      chk_all(tag, st, b, d, f);
      if (rst_off > 0 && p >= 0 && r == p + rst_off) begin
        reset = 1'b1;
        #1;
        chk_all({tag, ".async"}, ALL1, 0, 0, 0);
        bus.key_n = 1'b1; bus.done_in = 1'b0; bus.enable = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk_all({tag, ".held"}, ALL1, 0, 0, 0);
        end
        reset = 1'b0;
        hit_rst = 1'b1;
        break;
      end
      bus.key_n   = !key_low(r + 1, h1, s2, l2);
      bus.done_in = (p >= 0 && d_rel != 0 && r + 1 >= dd);
      bus.enable  = !(ab_off > 0 && p >= 0 && r + 1 >= p + ab_off);
      @(negedge clk);
    end
    bus.done_in = 1'b0;
    bus.key_n   = 1'b1;
    if (hit_rst) begin
      prev_done = 0; prev_fail = 0;
      @(negedge clk);
    end else begin
      bus.enable = 1'b1;
      prev_done = res_d; prev_fail = res_f;
    end
  endtask

  initial begin
    bus.key_n = 1'b1; bus.enable = 1'b0; bus.done_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset", ALL1, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_all("post_reset", ALL1, 0, 0, 0);
    end
`ifdef BSOD_SEQ_AUTOSTART_EN
    run_seq("auto", 0, 0, 0, 1, 5, 0, 0);
`endif
    run_seq("idle_en", 0, 0, 0, 0, 0, 0, 0);
    run_seq("full", 12, 0, 0, 0, 3, 0, 0);
    run_seq("bounce", 4, 0, 0, 0, 0, 0, 0);
    run_seq("timeout", 12, 40, 20, 0, 0, 0, 0);
    run_seq("pre_done", 12, 0, 0, 0, -5, 0, 0);
    run_seq("done_at_to", 12, 0, 0, 0, TO * TC, 0, 0);
    run_seq("to_plus1", 12, 0, 0, 0, TO * TC + 1, 0, 0);
    run_seq("abort", 12, 0, 0, 0, 0, (PU + GA) * TC + 3, 0);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      run_seq("rand", 12 + int'($urandom_range(0, 8)), 0, 0, 0, int'($urandom_range(0, 40)) - 4, 0, 0);
    end
    run_seq("mid_reset", 12, 0, 0, 0, 0, 0, PU * TC + 1);
`ifdef BSOD_SEQ_AUTOSTART_EN
    run_seq("auto2", 0, 0, 0, 1, 0, 0, 0);
    run_seq("auto_once", 0, 0, 0, 0, 0, 0, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
